// File: rtl/wash_pkg.sv
// Shared constants and timer helper for the washer sensing front end.
// Tick defaults assume a 100 MHz clock and a 1 s tick.
package wash_pkg;

   localparam int TW = 16;

   localparam int DEF_PRESCALE    = 100000000;
   localparam int DEF_CYCLE_TICKS = 1200;
   localparam int DEF_SPIN_TICKS  = 300;
   localparam int DEF_FILL_LIMIT  = 600;
   localparam int DEF_DEB_CYCLES  = 16;

   function automatic logic [TW-1:0] tmr_next(
      input logic          en,
      input logic          tick,
      input logic [TW-1:0] cnt,
      input logic [TW-1:0] tgt
   );
      logic [TW-1:0] r;
      r = cnt;
      if (!en)
         r = '0;
      else if (tick && cnt != tgt)
         r = cnt + 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/wash_timer_sense_if.sv
// Controller actuators and raw sensors in, conditioned levels and
// timeouts out; master is the board/controller side.
interface wash_timer_sense_if;
   import wash_pkg::*;

   logic          motor_on;
   logic          drain_value_on;
   logic          fill_value_on;
   logic          done;
   logic          filled_raw;
   logic          drained_raw;
   logic          door_raw;
   logic          filled;
   logic          drained;
   logic          door_close;
   logic          cycle_timeout;
   logic          spin_timeout;
   logic          fill_fault;
   logic [TW-1:0] time_left;

   modport master (
      output motor_on, drain_value_on, fill_value_on, done,
      output filled_raw, drained_raw, door_raw,
      input  filled, drained, door_close,
      input  cycle_timeout, spin_timeout, fill_fault, time_left
   );

   modport slave (
      input  motor_on, drain_value_on, fill_value_on, done,
      input  filled_raw, drained_raw, door_raw,
      output filled, drained, door_close,
      output cycle_timeout, spin_timeout, fill_fault, time_left
   );

endinterface

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stability counter; the level
// flips only after DEB_CYCLES consecutive differing samples.
module sensor_debounce #(
   parameter int DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o
);

   localparam logic [7:0] LAST = 8'(DEB_CYCLES - 1);

   logic [1:0] sync_q, sync_d;
   logic [7:0] cnt_q, cnt_d;
   logic       lvl_q, lvl_d;

   always_comb begin
      sync_d = {sync_q[0], raw_i};
      cnt_d  = '0;
      lvl_d  = lvl_q;
      if (sync_q[1] != lvl_q) begin
         if (cnt_q == LAST)
            lvl_d = ~lvl_q;
         else
            cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         lvl_q  <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         lvl_q  <= lvl_d;
      end
   end

   assign level_o = lvl_q;

endmodule

// File: rtl/wash_timer_sense.sv
// Sensor conditioning, phase timers, fill watchdog and time readout
// feeding the washing-machine controller.
module wash_timer_sense
   import wash_pkg::*;
#(
   parameter int PRESCALE    = DEF_PRESCALE,
   parameter int CYCLE_TICKS = DEF_CYCLE_TICKS,
   parameter int SPIN_TICKS  = DEF_SPIN_TICKS,
   parameter int FILL_LIMIT  = DEF_FILL_LIMIT,
   parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
   input logic               clk,
   input logic               reset,
   wash_timer_sense_if.slave bus
);

   localparam int            PW       = $clog2(PRESCALE);
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [TW-1:0] CYC_T    = TW'(CYCLE_TICKS);
   localparam logic [TW-1:0] SPIN_T   = TW'(SPIN_TICKS);
   localparam logic [TW-1:0] FILL_T   = TW'(FILL_LIMIT);

   logic filled_lvl, drained_lvl, door_lvl;

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_filled (
      .clk(clk), .reset(reset),
      .raw_i(bus.filled_raw), .level_o(filled_lvl)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_drained (
      .clk(clk), .reset(reset),
      .raw_i(bus.drained_raw), .level_o(drained_lvl)
   );

   sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_door (
      .clk(clk), .reset(reset),
      .raw_i(bus.door_raw), .level_o(door_lvl)
   );

   logic          cyc_en, spin_en, fill_en, any_en, sec_tick;
   logic [PW-1:0] pre_q, pre_d;
   logic [TW-1:0] cyc_cnt_q, cyc_cnt_d;
   logic [TW-1:0] spin_cnt_q, spin_cnt_d;
   logic [TW-1:0] fill_cnt_q, fill_cnt_d;
   logic          fault_q, fault_d;
   logic [TW-1:0] tl;

   // spin_en is only true once the tub is empty with the valve held open
   assign cyc_en  = bus.motor_on;
   assign spin_en = bus.drain_value_on & drained_lvl;
   assign fill_en = bus.fill_value_on;
   assign any_en  = cyc_en | spin_en | fill_en;

   always_comb begin
      sec_tick = any_en && (pre_q == PRE_LAST);
      pre_d    = pre_q + 1'b1;
      if (!any_en || sec_tick)
         pre_d = '0;
      cyc_cnt_d  = tmr_next(cyc_en, sec_tick, cyc_cnt_q, CYC_T);
      spin_cnt_d = tmr_next(spin_en, sec_tick, spin_cnt_q, SPIN_T);
      fill_cnt_d = tmr_next(fill_en, sec_tick, fill_cnt_q, FILL_T);
      // done beats a same-edge watchdog hit
      fault_d = bus.done ? 1'b0 : (fault_q | (fill_cnt_q == FILL_T));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_q      <= '0;
         cyc_cnt_q  <= '0;
         spin_cnt_q <= '0;
         fill_cnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         cyc_cnt_q  <= cyc_cnt_d;
         spin_cnt_q <= spin_cnt_d;
         fill_cnt_q <= fill_cnt_d;
         fault_q    <= fault_d;
      end
   end

   always_comb begin
      tl = '0;
      if (reset)
         tl = '0;
      else if (cyc_en)
         tl = CYC_T - cyc_cnt_q;
      else if (spin_en)
         tl = SPIN_T - spin_cnt_q;
   end

   assign bus.filled        = filled_lvl;
   assign bus.drained       = drained_lvl;
   assign bus.door_close    = door_lvl;
   assign bus.cycle_timeout = (cyc_cnt_q == CYC_T);
   assign bus.spin_timeout  = (spin_cnt_q == SPIN_T);
   assign bus.fill_fault    = fault_q;
   assign bus.time_left     = tl;

endmodule

// File: tb/tb_wash_timer_sense.sv
// Directed bench: PRESCALE=4, CYCLE=5, SPIN=3, FILL=6, DEB=3.
// Inputs change 1 ns after posedge, outputs are sampled on negedge.
module tb_wash_timer_sense;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wash_timer_sense_if bus();

   wash_timer_sense #(
      .PRESCALE(4), .CYCLE_TICKS(5), .SPIN_TICKS(3),
      .FILL_LIMIT(6), .DEB_CYCLES(3)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int errs = 0;
   int checks = 0;

   typedef struct {
      int          k;
      logic [15:0] tl;
      logic        to;
   } vec_t;

   vec_t tv[8];

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " filled"}, 16'(bus.filled), 16'd0);
      chk({tag, " drained"}, 16'(bus.drained), 16'd0);
      chk({tag, " door_close"}, 16'(bus.door_close), 16'd0);
      chk({tag, " cycle_to"}, 16'(bus.cycle_timeout), 16'd0);
      chk({tag, " spin_to"}, 16'(bus.spin_timeout), 16'd0);
      chk({tag, " fill_fault"}, 16'(bus.fill_fault), 16'd0);
      chk({tag, " time_left"}, bus.time_left, 16'd0);
   endtask

   task automatic drive_next();
      @(posedge clk);
      #1;
   endtask

   task automatic samp(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int cur;
      tv[0] = '{0, 16'd5, 1'b0};
      tv[1] = '{3, 16'd5, 1'b0};
      tv[2] = '{4, 16'd4, 1'b0};
      tv[3] = '{8, 16'd3, 1'b0};
      tv[4] = '{12, 16'd2, 1'b0};
      tv[5] = '{16, 16'd1, 1'b0};
      tv[6] = '{19, 16'd1, 1'b0};
      tv[7] = '{20, 16'd0, 1'b1};

      reset = 1'b1;
      bus.motor_on = 0; bus.drain_value_on = 0; bus.fill_value_on = 0;
      bus.done = 0; bus.filled_raw = 0; bus.drained_raw = 0;
      bus.door_raw = 0;
      #12;
      chk_zero("reset");
      drive_next();
      reset = 1'b0;

      // short level-switch glitch must be swallowed
      drive_next();
      bus.filled_raw = 1;
      repeat (2) @(posedge clk);
      #1;
      bus.filled_raw = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("glitch filled", 16'(bus.filled), 16'd0);
      end
      drive_next();
      bus.filled_raw = 1;
      samp(4);
      chk("filled early", 16'(bus.filled), 16'd0);
      samp(1);
      chk("filled rise", 16'(bus.filled), 16'd1);

      // agitation countdown
      drive_next();
      bus.motor_on = 1;
      cur = 0;
      for (int i = 0; i < 8; i++) begin
         samp(tv[i].k - cur);
         cur = tv[i].k;
         chk($sformatf("cyc tl k=%0d", tv[i].k), bus.time_left, tv[i].tl);
         chk($sformatf("cyc to k=%0d", tv[i].k),
             16'(bus.cycle_timeout), 16'(tv[i].to));
      end
      drive_next();
      bus.motor_on = 0;
      @(negedge clk);
      chk("cyc to hold", 16'(bus.cycle_timeout), 16'd1);
      chk("cyc tl off", bus.time_left, 16'd0);
      samp(1);
      chk("cyc to drop", 16'(bus.cycle_timeout), 16'd0);

      // brief motor drop restarts the phase
      drive_next();
      bus.motor_on = 1;
      repeat (12) @(posedge clk);
      #1;
      bus.motor_on = 0;
      drive_next();
      bus.motor_on = 1;
      samp(19);
      chk("restart early", 16'(bus.cycle_timeout), 16'd0);
      samp(1);
      chk("restart to", 16'(bus.cycle_timeout), 16'd1);
      drive_next();
      bus.motor_on = 0;
      samp(1);
      chk("restart drop", 16'(bus.cycle_timeout), 16'd0);

      // spin needs the debounced empty switch
      drive_next();
      bus.drain_value_on = 1;
      samp(20);
      chk("spin no drained", 16'(bus.spin_timeout), 16'd0);
      chk("spin tl idle", bus.time_left, 16'd0);
      drive_next();
      bus.drained_raw = 1;
      samp(5);
      chk("drained rise", 16'(bus.drained), 16'd1);
      chk("spin tl start", bus.time_left, 16'd3);
      samp(11);
      chk("spin early", 16'(bus.spin_timeout), 16'd0);
      samp(1);
      chk("spin to", 16'(bus.spin_timeout), 16'd1);
      drive_next();
      bus.drain_value_on = 0;
      samp(1);
      chk("spin drop", 16'(bus.spin_timeout), 16'd0);

      // fill watchdog sets, sticks, clears on done
      drive_next();
      bus.fill_value_on = 1;
      samp(23);
      chk("fault early", 16'(bus.fill_fault), 16'd0);
      samp(1);
      drive_next();
      bus.fill_value_on = 0;
      @(negedge clk);
      chk("fault set", 16'(bus.fill_fault), 16'd1);
      samp(5);
      chk("fault sticky", 16'(bus.fill_fault), 16'd1);
      drive_next();
      bus.done = 1;
      drive_next();
      bus.done = 0;
      @(negedge clk);
      chk("fault clear", 16'(bus.fill_fault), 16'd0);

      // done held while the watchdog fires: clear wins
      drive_next();
      bus.done = 1;
      bus.fill_value_on = 1;
      samp(30);
      chk("clear wins", 16'(bus.fill_fault), 16'd0);
      drive_next();
      bus.done = 0;
      @(negedge clk);
      chk("fault pend", 16'(bus.fill_fault), 16'd0);
      samp(1);
      chk("fault after done", 16'(bus.fill_fault), 16'd1);
      drive_next();
      bus.fill_value_on = 0;
      bus.done = 1;
      drive_next();
      bus.done = 0;

      // reset mid-run with random activity
      for (int i = 0; i < 40; i++) begin
         drive_next();
         bus.motor_on       = 1'($urandom_range(0, 1));
         bus.drain_value_on = 1'($urandom_range(0, 1));
         bus.fill_value_on  = 1'($urandom_range(0, 1));
         bus.filled_raw     = 1'($urandom_range(0, 1));
         bus.drained_raw    = 1'($urandom_range(0, 1));
         bus.door_raw       = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_zero("midrun reset");
      bus.motor_on = 0; bus.drain_value_on = 0; bus.fill_value_on = 0;
      bus.filled_raw = 0; bus.drained_raw = 0;
      bus.door_raw = 1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      samp(4);
      chk("door early", 16'(bus.door_close), 16'd0);
      samp(1);
      chk("door rise", 16'(bus.door_close), 16'd1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/wash_timer_sense.md
Name: wash_timer_sense

Overview:
- Front-end stage feeding the washing-machine controller.
- Conditions the raw level, drain and door sensors into clean levels: `filled`, `drained`, `door_close`.
- Generates `cycle_timeout` and `spin_timeout` from the controller's own actuator outputs; adds a fill watchdog and a remaining-time readout for the panel.
- Sits between the board sensors/clock and the controller; its outputs connect one-to-one to the controller's same-named inputs.

Parameters:
- PRESCALE, 100000000, clk cycles per 1 s tick (100 MHz clock); 2..2^27.
- CYCLE_TICKS, 1200, wash/rinse agitation duration in ticks; 1..65535.
- SPIN_TICKS, 300, spin duration in ticks; 1..65535.
- FILL_LIMIT, 600, max continuous fill time in ticks before fault; 1..65535.
- DEB_CYCLES, 16, consecutive stable clk samples required to change a debounced output; 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- motor_on  in  1  from controller; agitation running
- drain_value_on  in  1  from controller; drain valve open
- fill_value_on  in  1  from controller; fill valve open
- done  in  1  from controller; program complete
- filled_raw  in  1  raw level switch, asynchronous
- drained_raw  in  1  raw empty switch, asynchronous
- door_raw  in  1  raw door switch, asynchronous
- filled  out  1  debounced level
- drained  out  1  debounced empty
- door_close  out  1  debounced door closed
- cycle_timeout  out  1  agitation time elapsed
- spin_timeout  out  1  spin time elapsed
- fill_fault  out  1  sticky fill-watchdog fault
- time_left  out  16  ticks remaining in active timed phase

Behaviour:
Reset (async, active-high):
- All registers cleared.
- Every output is 0, including `door_close`, which reads as door open (safe state).

Debounce, one instance per sensor:
- 2-FF synchronizer, then a stability counter.
- The counter increments while the synchronized sample differs from the current output and clears when they match.
- The output toggles when the counter reaches DEB_CYCLES.
- Latency from a clean edge to the output is 2+DEB_CYCLES clk.
- A glitch shorter than DEB_CYCLES samples never propagates.

Enables:
- cyc_en = `motor_on`.
- spin_en = `drain_value_on` & `drained` (debounced). This is high only in the controller's spin phase, where the drain valve stays open after the tub is empty.
- fill_en = `fill_value_on`.

Prescaler:
- Counts 0..PRESCALE-1 while any enable is high and pulses `sec_tick` on the wrap.
- Held at 0 whenever all enables are low.
- The controller drops all enables for at least one clk between phases, so every phase starts with a full first tick.

Timers (16-bit each):
- The counter increments on `sec_tick` while its enable is high and saturates at its target.
- It clears at the clock edge where its enable is low.
- `cycle_timeout` = (cycle_cnt == CYCLE_TICKS) and `spin_timeout` = (spin_cnt == SPIN_TICKS). Both are decoded from registers only, with no combinational path from the enables. This is required because the controller drops `motor_on`/`drain_value_on` combinationally on timeout.
- Each timeout goes high exactly N×PRESCALE clk after its enable is first sampled high. It returns low one edge after the enable falls.

Fill watchdog:
- fill_cnt counts the same way with fill_en.
- When fill_cnt reaches FILL_LIMIT, `fill_fault` sets and stays set, even if `fill_value_on` drops.
- Cleared only by `reset` or by `done`=1 sampled at an edge.
- If set and clear occur in the same edge, clear wins.

time_left:
- CYCLE_TICKS−cycle_cnt if cyc_en, else SPIN_TICKS−spin_cnt if spin_en, else 0. Combinational from registers.

Illegal overlap:
- If cyc_en and spin_en are high together, both timers run independently and time_left reports the cycle timer.

Reset mid-phase:
- All counters and debouncers return to 0 immediately.
- After release, timing restarts from the first sampled enable.

Decomposition:
- Package `wash_pkg`: the timer width constant (16) and default tick constants.
- Sub-module `sensor_debounce`: synchronizer plus stability counter, instantiated 3×.
- Timers, prescaler and watchdog stay inline.

Test Plan:
Bench overrides: PRESCALE=4, CYCLE_TICKS=5, SPIN_TICKS=3, FILL_LIMIT=6, DEB_CYCLES=3.
1. Assert `reset` mid-run with random inputs -> all outputs 0 in the same cycle; after release `door_close`=0 until `door_raw` is stable for 5 clk.
2. `filled_raw` pulse of 2 clk -> `filled` stays 0; `filled_raw` held high -> `filled` rises 5 clk after the edge.
3. `motor_on` held -> `time_left` steps 5,4,3,2,1 every 4 clk, then `cycle_timeout`=1 at clk 20; drop `motor_on` -> `cycle_timeout`=0 next edge.
4. `motor_on` high for 12 clk, low 1 clk, high again -> `cycle_timeout` rises 20 clk after the reassertion, not before.
5. `drain_value_on`=1 with `drained`=0 -> no `spin_timeout`; `drained` becomes 1 -> `spin_timeout` 12 clk later.
6. `fill_value_on` held 24 clk -> `fill_fault`=1 and stays set after the valve drops; one-clk `done` pulse -> `fill_fault`=0.
